// File: rtl/cache_arb_pkg.sv
// Shared encodings for the cache bus arbiter: read/write-buffer states,
// requester indices and the latched read request.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_EMPTY = 1'b0,
    W_FULL  = 1'b1
  } wr_state_e;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        burst;
  } rd_req_t;

endpackage

// File: rtl/cache_wr_buf.sv
// Single-entry dcache write buffer; exposes the buffered address and full
// flag so the arbiter can block reads that hit the pending line.
module cache_wr_buf
  import cache_arb_pkg::*;
#(
  parameter int LW = 128
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          d_wr_req,
  input  logic [31:0]   d_wr_addr,
  input  logic [3:0]    d_wr_strb,
  input  logic [1:0]    d_wr_size,
  input  logic          d_wr_burst,
  input  logic [LW-1:0] d_wr_data,
  output logic          d_wr_rdy,
  output logic [3:0]    m_wr_strb,
  output logic [1:0]    m_wr_size,
  output logic          m_wr_burst,
  output logic [LW-1:0] m_wr_data,
  input  logic          m_wr_rdy,
  output logic [31:0]   buf_addr,
  output logic          buf_full
);

  wr_state_e state, state_nxt;
  logic      capture;

  // a request arriving while full is dropped, not queued
  assign capture = (state == W_EMPTY) && d_wr_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= W_EMPTY;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_addr   <= '0;
      m_wr_strb  <= '0;
      m_wr_size  <= '0;
      m_wr_burst <= 1'b0;
      m_wr_data  <= '0;
    end else if (capture) begin
      buf_addr   <= d_wr_addr;
      m_wr_strb  <= d_wr_strb;
      m_wr_size  <= d_wr_size;
      m_wr_burst <= d_wr_burst;
      m_wr_data  <= d_wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_EMPTY: if (d_wr_req) state_nxt = W_FULL;
      W_FULL:  if (m_wr_rdy) state_nxt = W_EMPTY;
      default: state_nxt = W_EMPTY;
    endcase
  end

  assign buf_full = (state == W_FULL);
  assign d_wr_rdy = (state == W_EMPTY);

endmodule

// File: rtl/cache_bus_arb.sv
// Arbitrates icache/dcache reads onto one memory read port (one outstanding)
// and buffers dcache writes. CACHE_ARB_RR_EN selects round-robin arbitration.
module cache_bus_arb
  import cache_arb_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16,
  parameter int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        i_rd_req,
  input  logic [31:0]                 i_rd_addr,
  input  logic [1:0]                  i_rd_size,
  input  logic                        i_burst,
  input  logic                        d_rd_req,
  input  logic [31:0]                 d_rd_addr,
  input  logic [1:0]                  d_rd_size,
  input  logic                        d_burst,
  output logic                        i_rd_rdy,
  output logic                        i_ret_valid,
  output logic                        i_ret_last,
  output logic [31:0]                 i_ret_data,
  output logic                        d_rd_rdy,
  output logic                        d_ret_valid,
  output logic                        d_ret_last,
  output logic [31:0]                 d_ret_data,
  input  logic                        d_wr_req,
  input  logic [31:0]                 d_wr_addr,
  input  logic [3:0]                  d_wr_strb,
  input  logic [1:0]                  d_wr_size,
  input  logic                        d_wr_burst,
  input  logic [BYTES_PER_LINE*8-1:0] d_wr_data,
  output logic                        d_wr_rdy,
  output logic                        m_rd_req,
  output logic [31:0]                 m_rd_addr,
  output logic [1:0]                  m_rd_size,
  output logic                        m_burst,
  input  logic                        m_rd_rdy,
  input  logic                        m_ret_valid,
  input  logic                        m_ret_last,
  input  logic [31:0]                 m_ret_data,
  output logic                        m_wr_req,
  output logic [31:0]                 m_wr_addr,
  output logic [3:0]                  m_wr_strb,
  output logic [1:0]                  m_wr_size,
  output logic                        m_wr_burst,
  output logic [BYTES_PER_LINE*8-1:0] m_wr_data,
  input  logic                        m_wr_rdy
);

  localparam int LW = BYTES_PER_LINE * 8;

  rd_state_e   rd_state, rd_state_nxt;
  logic        owner;
  rd_req_t     rd_lat;
  logic [31:0] wb_addr;
  logic        wb_full;
  logic [1:0]  hazard, elig;
  logic        grant, win;

  cache_wr_buf #(.LW(LW)) u_wr_buf (
    .clk        (clk),
    .resetn     (resetn),
    .d_wr_req   (d_wr_req),
    .d_wr_addr  (d_wr_addr),
    .d_wr_strb  (d_wr_strb),
    .d_wr_size  (d_wr_size),
    .d_wr_burst (d_wr_burst),
    .d_wr_data  (d_wr_data),
    .d_wr_rdy   (d_wr_rdy),
    .m_wr_strb  (m_wr_strb),
    .m_wr_size  (m_wr_size),
    .m_wr_burst (m_wr_burst),
    .m_wr_data  (m_wr_data),
    .m_wr_rdy   (m_wr_rdy),
    .buf_addr   (wb_addr),
    .buf_full   (wb_full)
  );

  assign m_wr_req  = wb_full;
  assign m_wr_addr = wb_addr;

  // registered full flag: a drain only unblocks the line one cycle later
  assign hazard[REQ_ICACHE] = wb_full && (i_rd_addr[31:OFFSET_WIDTH] == wb_addr[31:OFFSET_WIDTH]);
  assign hazard[REQ_DCACHE] = wb_full && (d_rd_addr[31:OFFSET_WIDTH] == wb_addr[31:OFFSET_WIDTH]);
  assign elig[REQ_ICACHE]   = i_rd_req && !hazard[REQ_ICACHE];
  assign elig[REQ_DCACHE]   = d_rd_req && !hazard[REQ_DCACHE];
  assign grant              = (rd_state == R_IDLE) && (|elig);

`ifdef CACHE_ARB_RR_EN
  logic rr_ptr;  // requester favoured on a tie

  assign win = (&elig) ? rr_ptr : elig[REQ_DCACHE];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    rr_ptr <= REQ_DCACHE;
    else if (grant) rr_ptr <= ~win;
  end
`else
  assign win = elig[REQ_DCACHE] ? REQ_DCACHE : REQ_ICACHE;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      owner    <= REQ_ICACHE;
      rd_lat   <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (grant) begin
        owner  <= win;
        rd_lat <= (win == REQ_DCACHE) ? '{d_rd_addr, d_rd_size, d_burst}
                                      : '{i_rd_addr, i_rd_size, i_burst};
      end
    end
  end

  assign m_rd_addr = rd_lat.addr;
  assign m_rd_size = rd_lat.size;
  assign m_burst   = rd_lat.burst;

  always_comb begin
    rd_state_nxt = rd_state;
    m_rd_req     = 1'b0;
    i_rd_rdy     = 1'b0;
    d_rd_rdy     = 1'b0;
    i_ret_valid  = 1'b0;
    i_ret_last   = 1'b0;
    i_ret_data   = '0;
    d_ret_valid  = 1'b0;
    d_ret_last   = 1'b0;
    d_ret_data   = '0;
    case (rd_state)
      R_IDLE: if (grant) rd_state_nxt = R_REQ;
      R_REQ: begin
        m_rd_req = 1'b1;
        if (owner == REQ_DCACHE) d_rd_rdy = m_rd_rdy;
        else                     i_rd_rdy = m_rd_rdy;
        if (m_rd_rdy) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (owner == REQ_DCACHE) begin
          d_ret_valid = m_ret_valid;
          d_ret_last  = m_ret_last;
          d_ret_data  = m_ret_data;
        end else begin
          i_ret_valid = m_ret_valid;
          i_ret_last  = m_ret_last;
          i_ret_data  = m_ret_data;
        end
        if (m_ret_valid && m_ret_last) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_bus_arb.sv
// Scoreboard bench for cache_bus_arb: expected grants, return beats and
// write drains are queued at stimulus time and popped by a negedge monitor.
module tb_cache_bus_arb;
  import cache_arb_pkg::*;

  localparam int LW = 128;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          i_rd_req, i_burst, d_rd_req, d_burst;
  logic [31:0]   i_rd_addr, d_rd_addr;
  logic [1:0]    i_rd_size, d_rd_size;
  logic          i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [31:0]   i_ret_data, d_ret_data;
  logic          d_wr_req, d_wr_burst, d_wr_rdy;
  logic [31:0]   d_wr_addr;
  logic [3:0]    d_wr_strb;
  logic [1:0]    d_wr_size;
  logic [LW-1:0] d_wr_data;
  logic          m_rd_req, m_burst, m_rd_rdy, m_ret_valid, m_ret_last;
  logic [31:0]   m_rd_addr, m_ret_data;
  logic [1:0]    m_rd_size;
  logic          m_wr_req, m_wr_burst, m_wr_rdy;
  logic [31:0]   m_wr_addr;
  logic [3:0]    m_wr_strb;
  logic [1:0]    m_wr_size;
  logic [LW-1:0] m_wr_data;

  cache_bus_arb dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_size(i_rd_size), .i_burst(i_burst),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_size(d_rd_size), .d_burst(d_burst),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_strb(d_wr_strb), .d_wr_size(d_wr_size),
    .d_wr_burst(d_wr_burst), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_size(m_rd_size), .m_burst(m_burst),
    .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_strb(m_wr_strb), .m_wr_size(m_wr_size),
    .m_wr_burst(m_wr_burst), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy)
  );

  typedef struct { logic who; logic [31:0] addr; } gnt_t;
  typedef struct { logic who; logic [31:0] data; logic last; } ret_t;
  typedef struct { logic [31:0] addr; logic [3:0] strb; logic [LW-1:0] data; } wr_t;

  gnt_t gnt_q[$];
  ret_t ret_q[$];
  wr_t  wr_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ret(input logic who, input int nb, input logic [31:0] base, input int upto);
    for (int b = 0; b < nb && b < upto; b++)
      ret_q.push_back('{who, base + b, (b == nb - 1)});
  endtask

  // memory read model: accept the pending request, return nb beats;
  // drop: 0 keep requests, 1 drop owner's, 2 drop both; rst_beat<0: no reset
  task automatic serve(input int nb, input logic [31:0] base, input int drop, input int rst_beat);
    int   c = 0;
    logic own_d;
    while (!m_rd_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!m_rd_req) begin
      chk("rd_req_timeout", 1'b0, 1'b1);
      return;
    end
    tick();
    m_rd_rdy = 1'b1;
    @(negedge clk);
    own_d = d_rd_rdy;
    tick();
    m_rd_rdy = 1'b0;
    if (drop == 2) begin
      i_rd_req = 1'b0;
      d_rd_req = 1'b0;
    end else if (drop == 1) begin
      if (own_d) d_rd_req = 1'b0;
      else       i_rd_req = 1'b0;
    end
    for (int b = 0; b < nb; b++) begin
      if (b == rst_beat)     resetn = 1'b0;
      if (b == rst_beat + 1) resetn = 1'b1;
      m_ret_valid = 1'b1;
      m_ret_data  = base + b;
      m_ret_last  = (b == nb - 1);
      tick();
    end
    m_ret_valid = 1'b0;
    m_ret_last  = 1'b0;
    resetn      = 1'b1;
  endtask

  always @(negedge clk) begin
    gnt_t g;
    ret_t r;
    wr_t  w;
    if (m_rd_req && m_rd_rdy) begin
      if (gnt_q.size() == 0) chk("unexpected_grant", 1'b1, 1'b0);
      else begin
        g = gnt_q.pop_front();
        chk("grant_who", {i_rd_rdy, d_rd_rdy}, g.who ? 2'b01 : 2'b10);
        chk("grant_addr", m_rd_addr, g.addr);
      end
    end
    if (i_ret_valid || d_ret_valid) begin
      if (ret_q.size() == 0) chk("spurious_ret", 1'b1, 1'b0);
      else begin
        r = ret_q.pop_front();
        chk("ret_owner", {i_ret_valid, d_ret_valid}, r.who ? 2'b01 : 2'b10);
        chk("ret_data", r.who ? d_ret_data : i_ret_data, r.data);
        chk("ret_last", r.who ? d_ret_last : i_ret_last, r.last);
      end
    end
    if (m_wr_req && m_wr_rdy) begin
      if (wr_q.size() == 0) chk("unexpected_wr", 1'b1, 1'b0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", m_wr_addr, w.addr);
        chk("wr_strb", m_wr_strb, w.strb);
        chk("wr_data", m_wr_data, w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rd_req = 0; i_rd_addr = 0; i_rd_size = 0; i_burst = 0;
    d_rd_req = 0; d_rd_addr = 0; d_rd_size = 0; d_burst = 0;
    d_wr_req = 0; d_wr_addr = 0; d_wr_strb = 0; d_wr_size = 0; d_wr_burst = 0; d_wr_data = '0;
    m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0; m_wr_rdy = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_m_rd_req", m_rd_req, 1'b0);
    chk("rst_m_wr_req", m_wr_req, 1'b0);
    chk("rst_rdy_valid", {i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid}, 4'b0);
    chk("rst_d_wr_rdy", d_wr_rdy, 1'b1);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_m_rd_req", m_rd_req, 1'b0);
    chk("post_rst_d_wr_rdy", d_wr_rdy, 1'b1);

    // simultaneous reads: dcache first, latency 1, icache after ret_last
    tick();
    i_rd_req = 1; i_rd_addr = 32'h2000_0100; i_rd_size = 2'd2; i_burst = 0;
    d_rd_req = 1; d_rd_addr = 32'h3000_0200; d_rd_size = 2'd1; d_burst = 1;
    gnt_q.push_back('{REQ_DCACHE, 32'h3000_0200});
    push_ret(REQ_DCACHE, 4, 32'hD0, 4);
    gnt_q.push_back('{REQ_ICACHE, 32'h2000_0100});
    push_ret(REQ_ICACHE, 1, 32'h11, 1);
    @(negedge clk);
    chk("lat_t", m_rd_req, 1'b0);
    @(negedge clk);
    chk("lat_t1", m_rd_req, 1'b1);
    chk("lat_addr", m_rd_addr, 32'h3000_0200);
    chk("lat_size", m_rd_size, 2'd1);
    chk("lat_burst", m_burst, 1'b1);
    serve(4, 32'hD0, 1, -1);
    serve(1, 32'h11, 1, -1);

    // icache 4-beat burst
    tick();
    i_rd_req = 1; i_rd_addr = 32'h2000_0200; i_burst = 1;
    gnt_q.push_back('{REQ_ICACHE, 32'h2000_0200});
    push_ret(REQ_ICACHE, 4, 32'hA0, 4);
    serve(4, 32'hA0, 1, -1);

    // read-after-write hazard on the buffered line
    tick();
    d_wr_req = 1; d_wr_addr = 32'h1000_0040; d_wr_strb = 4'hF; d_wr_size = 2'd2; d_wr_burst = 1;
    d_wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    wr_q.push_back('{32'h1000_0040, 4'hF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210});
    tick();
    d_wr_req = 0; i_rd_req = 1; i_rd_addr = 32'h1000_004C; i_burst = 0;
    @(negedge clk);
    chk("wb_full_rdy", d_wr_rdy, 1'b0);
    chk("wb_m_wr_req", m_wr_req, 1'b1);
    tick();
    d_wr_req = 1; d_wr_addr = 32'h5555_0000; d_wr_strb = 4'h1;
    tick();
    d_wr_req = 0;
    m_ret_valid = 1; m_ret_last = 1; m_ret_data = 32'hBAD;
    tick();
    m_ret_valid = 0; m_ret_last = 0;
    chk("wb_ignore_addr", m_wr_addr, 32'h1000_0040);
    chk("wb_ignore_strb", m_wr_strb, 4'hF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hz_block", m_rd_req, 1'b0);
    end
    tick();
    m_wr_rdy = 1;
    @(negedge clk);
    chk("hz_drain_cycle", m_rd_req, 1'b0);
    tick();
    m_wr_rdy = 0;
    @(negedge clk);
    chk("hz_after_drain", m_rd_req, 1'b0);
    chk("hz_wr_rdy", d_wr_rdy, 1'b1);
    gnt_q.push_back('{REQ_ICACHE, 32'h1000_004C});
    push_ret(REQ_ICACHE, 1, 32'h77, 1);
    @(negedge clk);
    chk("hz_grant", m_rd_req, 1'b1);
    serve(1, 32'h77, 1, -1);

    // capture and grant in one cycle: grant sees the pre-capture buffer
    tick();
    d_wr_req = 1; d_wr_addr = 32'h1000_0080; d_wr_strb = 4'h3;
    d_wr_data = 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF;
    wr_q.push_back('{32'h1000_0080, 4'h3, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF});
    d_rd_req = 1; d_rd_addr = 32'h1000_0084; d_burst = 0;
    gnt_q.push_back('{REQ_DCACHE, 32'h1000_0084});
    push_ret(REQ_DCACHE, 2, 32'hB0, 2);
    tick();
    d_wr_req = 0;
    @(negedge clk);
    chk("cap_grant_rd", m_rd_req, 1'b1);
    chk("cap_grant_wr", m_wr_req, 1'b1);
    serve(2, 32'hB0, 1, -1);

    // drain and a non-conflicting grant in the same cycle
    tick();
    d_rd_req = 1; d_rd_addr = 32'h4000_0000; m_wr_rdy = 1;
    gnt_q.push_back('{REQ_DCACHE, 32'h4000_0000});
    push_ret(REQ_DCACHE, 1, 32'hC0, 1);
    tick();
    m_wr_rdy = 0;
    @(negedge clk);
    chk("par_rd_req", m_rd_req, 1'b1);
    chk("par_wr_rdy", d_wr_rdy, 1'b1);
    chk("par_m_wr_req", m_wr_req, 1'b0);
    serve(1, 32'hC0, 1, -1);

    // reset during beat 2 of a burst: later beats are dropped
    tick();
    d_rd_req = 1; d_rd_addr = 32'h5000_0000; d_burst = 1;
    gnt_q.push_back('{REQ_DCACHE, 32'h5000_0000});
    push_ret(REQ_DCACHE, 4, 32'hE0, 2);
    serve(4, 32'hE0, 1, 2);
    @(negedge clk);
    chk("midrst_m_rd_req", m_rd_req, 1'b0);
    chk("midrst_valid", {i_ret_valid, d_ret_valid}, 2'b0);
    chk("midrst_wr_rdy", d_wr_rdy, 1'b1);

    // continuous contention from reset pointer state
    tick();
    i_rd_req = 1; i_rd_addr = 32'h6000_0000;
    d_rd_req = 1; d_rd_addr = 32'h7000_0000;
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_RR_EN
      logic who = (k % 2 == 0);
`else
      logic who = 1'b1;
`endif
      gnt_q.push_back('{who, who ? 32'h7000_0000 : 32'h6000_0000});
      push_ret(who, 1, 32'hF0 + k, 1);
      serve(1, 32'hF0 + k, (k == 3) ? 2 : 0, -1);
    end

    repeat (4) @(negedge clk);
    chk("end_idle", m_rd_req, 1'b0);
    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("ret_q_empty", ret_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
